uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_tx_fifo.sv | 52 +++++
 rtl/uart_tx_cfg.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the configurable UART transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2,
      PAR_RSVD = 2'd3
   } parity_e;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   // Fallback divisor, clamped into the 16-bit timer range.
   function automatic logic [15:0] def_div(
      input int unsigned clk_freq,
      input int unsigned baud_rate
   );
      int unsigned d;
      d = (baud_rate == 0) ? 1 : clk_freq / baud_rate;
      if (d < 1) d = 1;
      if (d > 65535) d = 65535;
      return 16'(d);
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit word queue, count-based full/empty,
// pointers wrap modulo DEPTH (power of two).
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_q];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_q] <= wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         count <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: FIFO-fed UART transmitter with per-frame
// divisor, parity and stop-bit configuration.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 115_200
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          ena,
   input  logic [DATA_WIDTH-1:0]         tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   input  logic [15:0]                   baud_div,
   input  logic [1:0]                    parity_mode,
   input  logic                          two_stop,
   output logic                          txd,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam logic [15:0] DEF_DIV  = def_div(CLK_FREQ, BAUD_RATE);
   localparam logic [3:0]  BIT_LAST = 4'(DATA_WIDTH-1);

   logic                  fifo_full;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_rdata;
   logic                  push;
   logic                  pop;

   tx_state_e             state_q, state_d;
   logic [15:0]           timer_q, timer_d;
   logic [3:0]            bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [15:0]           div_q, div_d;
   parity_e               par_q, par_d;
   logic                  par_bit_q, par_bit_d;
   logic                  two_q, two_d;
   logic                  stop2_q, stop2_d;

   logic                  tick;
   logic                  par_en;
   logic                  start_frame;
   logic [15:0]           cfg_div;
   parity_e               cfg_par;

   assign push       = tx_valid && !fifo_full;
   assign tx_ready   = !fifo_full;
   assign busy       = (state_q != IDLE) || !fifo_empty;
   assign cfg_div    = (baud_div < 16'd2) ? DEF_DIV : baud_div;
   assign cfg_par    = parity_e'(parity_mode);
   assign par_en     = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
   assign tick       = ena && (timer_q == div_q - 16'd1);

   uart_tx_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (tx_data),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         bit_q     <= '0;
         shreg_q   <= '0;
         div_q     <= '0;
         par_q     <= PAR_NONE;
         par_bit_q <= 1'b0;
         two_q     <= 1'b0;
         stop2_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_q     <= bit_d;
         shreg_q   <= shreg_d;
         div_q     <= div_d;
         par_q     <= par_d;
         par_bit_q <= par_bit_d;
         two_q     <= two_d;
         stop2_q   <= stop2_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      bit_d       = bit_q;
      shreg_d     = shreg_q;
      div_d       = div_q;
      par_d       = par_q;
      par_bit_d   = par_bit_q;
      two_d       = two_q;
      stop2_d     = stop2_q;
      pop         = 1'b0;
      start_frame = 1'b0;

      if (state_q != IDLE && ena) begin
         timer_d = tick ? 16'd0 : timer_q + 16'd1;
      end

      unique case (state_q)
         IDLE: begin
            if (ena && !fifo_empty) start_frame = 1'b1;
         end
         START: begin
            if (tick) begin
               state_d = DATA;
               bit_d   = '0;
            end
         end
         DATA: begin
            if (tick) begin
               shreg_d = shreg_q >> 1;
               bit_d   = bit_q + 4'd1;
               if (bit_q == BIT_LAST) begin
                  state_d = par_en ? PARITY : STOP;
                  stop2_d = 1'b0;
               end
            end
         end
         PARITY: begin
            if (tick) state_d = STOP;
         end
         STOP: begin
            // tick implies ena, so a queued word chains straight in.
            if (tick) begin
               if (two_q && !stop2_q) stop2_d = 1'b1;
               else if (!fifo_empty)  start_frame = 1'b1;
               else                   state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (start_frame) begin
         pop       = 1'b1;
         state_d   = START;
         timer_d   = '0;
         bit_d     = '0;
         shreg_d   = fifo_rdata;
         div_d     = cfg_div;
         par_d     = cfg_par;
         par_bit_d = (^fifo_rdata) ^ (cfg_par == PAR_ODD);
         two_d     = two_stop;
         stop2_d   = 1'b0;
      end
   end

   always_comb begin
      txd = 1'b1;
      unique case (state_q)
         START:   txd = 1'b0;
         DATA:    txd = shreg_q[0];
         PARITY:  txd = par_bit_q;
         default: txd = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: randomized self-checking bench comparing the serial
// line against a frame-level waveform model.
module tb_uart_tx_cfg;

   localparam int DW      = 8;
   localparam int DEPTH   = 4;
   localparam int DEF_DIV = 50_000_000 / 115_200;

   logic          clk = 1'b0;
   logic          reset;
   logic          ena;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic [15:0]   baud_div;
   logic [1:0]    parity_mode;
   logic          two_stop;
   logic          txd;
   logic          busy;
   logic [2:0]    fifo_count;

   int checks = 0;
   int passes = 0;
   bit exp_q[$];
   bit got_q[$];

   always #5 clk = ~clk;

   uart_tx_cfg #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH),
      .CLK_FREQ   (50_000_000),
      .BAUD_RATE  (115_200)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ena         (ena),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .baud_div    (baud_div),
      .parity_mode (parity_mode),
      .two_stop    (two_stop),
      .txd         (txd),
      .busy        (busy),
      .fifo_count  (fifo_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int eff_div(input int bd);
      return (bd < 2) ? DEF_DIV : bd;
   endfunction

   // Line levels of one frame, each held for div cycles.
   task automatic add_frame(input logic [DW-1:0] d, input int div,
                            input int pm, input bit ts);
      bit lv[$];
      lv.push_back(1'b0);
      for (int i = 0; i < DW; i++) lv.push_back(d[i]);
      if (pm == 1) lv.push_back(^d);
      if (pm == 2) lv.push_back(~^d);
      lv.push_back(1'b1);
      if (ts) lv.push_back(1'b1);
      foreach (lv[k]) repeat (div) exp_q.push_back(lv[k]);
   endtask

   function automatic int first_mismatch();
      int n;
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
      if (got_q.size() != exp_q.size()) return n;
      return -1;
   endfunction

   task automatic wait_low(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         step();
         if (txd === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_idle(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if (busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   // ena is dropped for three edges after sample index stall_at.
   task automatic capture_to_end(input int stall_at);
      int i;
      while (got_q.size() < exp_q.size()) begin
         step();
         got_q.push_back(txd);
         i = got_q.size() - 1;
         if (i == stall_at) ena = 1'b0;
         if (i == stall_at + 3) ena = 1'b1;
      end
   endtask

   task automatic apply_reset();
      reset       = 1'b1;
      ena         = 1'b0;
      tx_valid    = 1'b0;
      tx_data     = '0;
      baud_div    = 16'd4;
      parity_mode = 2'd0;
      two_stop    = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      step();
   endtask

   task automatic push_word(input logic [DW-1:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (txd !== 1'b1) $display("FAIL reset_txd got %b want 1", txd);
      else passes++;
      checks++;
      if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
      else passes++;
      checks++;
      if (tx_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", tx_ready);
      else passes++;
      checks++;
      if (fifo_count !== 3'd0) $display("FAIL reset_count got %0d want 0", fifo_count);
      else passes++;
   endtask

   task automatic test_basic();
      int mm;
      bit ok;
      ena = 1'b1;
      baud_div = 16'd4;
      parity_mode = 2'd0;
      two_stop = 1'b0;
      exp_q = {};
      add_frame(8'hA5, 4, 0, 1'b0);
      push_word(8'hA5);
      checks++;
      if (txd !== 1'b1) $display("FAIL basic_pre_start got %b want 1", txd);
      else passes++;
      step();
      checks++;
      if (txd !== 1'b0) $display("FAIL basic_start_latency got %b want 0", txd);
      else passes++;
      got_q = {};
      got_q.push_back(txd);
      capture_to_end(-10);
      mm = first_mismatch();
      checks++;
      if (mm !== -1)
         $display("FAIL basic_a5 idx %0d got %b want %b", mm, got_q[mm], exp_q[mm]);
      else passes++;
      step();
      checks++;
      if (busy !== 1'b0 || txd !== 1'b1)
         $display("FAIL basic_end busy %b txd %b want 0 1", busy, txd);
      else passes++;
      wait_idle(10, ok);
   endtask

   task automatic test_parity();
      int mm;
      bit ok;
      logic want;
      for (int pm = 1; pm <= 2; pm++) begin
         baud_div = 16'd4;
         parity_mode = 2'(pm);
         two_stop = 1'b1;
         exp_q = {};
         add_frame(8'h03, 4, pm, 1'b1);
         push_word(8'h03);
         wait_low(8, ok);
         checks++;
         if (!ok) $display("FAIL parity_start pm %0d no start bit", pm);
         else passes++;
         got_q = {};
         got_q.push_back(txd);
         capture_to_end(-10);
         mm = first_mismatch();
         checks++;
         if (mm !== -1)
            $display("FAIL parity_frame pm %0d idx %0d got %b want %b", pm, mm, got_q[mm], exp_q[mm]);
         else passes++;
         want = (pm == 2);
         checks++;
         if (got_q[36] !== want)
            $display("FAIL parity_bit pm %0d got %b want %b", pm, got_q[36], want);
         else passes++;
         step();
         checks++;
         if (busy !== 1'b0) $display("FAIL parity_end pm %0d busy %b want 0", pm, busy);
         else passes++;
      end
   endtask

   task automatic test_random();
      int mm;
      int bd;
      int pm;
      bit ts;
      bit ok;
      logic [DW-1:0] d;
      for (int n = 0; n < 6; n++) begin
         d  = DW'($urandom);
         pm = $urandom_range(0, 3);
         ts = 1'($urandom);
         bd = (n == 2) ? $urandom_range(0, 1) : $urandom_range(2, 12);
         baud_div = 16'(bd);
         parity_mode = 2'(pm);
         two_stop = ts;
         exp_q = {};
         add_frame(d, eff_div(bd), pm, ts);
         push_word(d);
         wait_low(8, ok);
         // Config changes mid-frame must not disturb the running frame.
         baud_div = 16'($urandom);
         parity_mode = 2'($urandom);
         two_stop = 1'($urandom);
         got_q = {};
         got_q.push_back(txd);
         capture_to_end(-10);
         mm = first_mismatch();
         checks++;
         if (!ok || mm !== -1)
            $display("FAIL random_frame %0d d %h pm %0d ts %0d bd %0d idx %0d", n, d, pm, ts, bd, mm);
         else passes++;
         step();
         wait_idle(20, ok);
      end
   endtask

   task automatic test_full();
      logic [DW-1:0] w [5];
      int mm;
      bit ok;
      ena = 1'b0;
      baud_div = 16'd3;
      parity_mode = 2'd0;
      two_stop = 1'b0;
      for (int i = 0; i < 5; i++) w[i] = DW'($urandom);
      tx_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tx_data = w[i];
         step();
         if (i == 3) begin
            checks++;
            if (fifo_count !== 3'd4 || tx_ready !== 1'b0)
               $display("FAIL full_after4 count %0d ready %b want 4 0", fifo_count, tx_ready);
            else passes++;
         end
      end
      tx_valid = 1'b0;
      checks++;
      if (fifo_count !== 3'd4) $display("FAIL full_refuse count %0d want 4", fifo_count);
      else passes++;
      checks++;
      if (txd !== 1'b1 || busy !== 1'b1)
         $display("FAIL full_hold txd %b busy %b want 1 1", txd, busy);
      else passes++;
      exp_q = {};
      for (int i = 0; i < 4; i++) add_frame(w[i], 3, 0, 1'b0);
      ena = 1'b1;
      wait_low(4, ok);
      got_q = {};
      got_q.push_back(txd);
      capture_to_end(-10);
      mm = first_mismatch();
      checks++;
      if (!ok || mm !== -1) $display("FAIL full_drain idx %0d ok %b", mm, ok);
      else passes++;
      step();
      checks++;
      if (busy !== 1'b0) $display("FAIL full_drain_end busy %b want 0", busy);
      else passes++;
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] w [3];
      int mm;
      int pm;
      bit ts;
      pm = $urandom_range(0, 2);
      ts = 1'($urandom);
      ena = 1'b1;
      baud_div = 16'd5;
      parity_mode = 2'(pm);
      two_stop = ts;
      exp_q = {};
      for (int i = 0; i < 3; i++) begin
         w[i] = DW'($urandom);
         add_frame(w[i], 5, pm, ts);
      end
      tx_valid = 1'b1;
      tx_data = w[0];
      step();
      tx_data = w[1];
      step();
      got_q = {};
      got_q.push_back(txd);
      tx_data = w[2];
      step();
      got_q.push_back(txd);
      tx_valid = 1'b0;
      capture_to_end(-10);
      mm = first_mismatch();
      checks++;
      if (mm !== -1) $display("FAIL b2b_stream idx %0d pm %0d ts %0d", mm, pm, ts);
      else passes++;
      step();
      checks++;
      if (busy !== 1'b0) $display("FAIL b2b_end busy %b want 0", busy);
      else passes++;
   endtask

   task automatic test_reset_mid();
      int lows;
      int mm;
      bit ok;
      logic [DW-1:0] d;
      ena = 1'b0;
      baud_div = 16'd4;
      parity_mode = 2'd0;
      two_stop = 1'b0;
      for (int i = 0; i < 3; i++) push_word(DW'($urandom));
      ena = 1'b1;
      wait_low(4, ok);
      repeat (14) step();
      checks++;
      if (fifo_count !== 3'd2) $display("FAIL rst_mid_pre count %0d want 2", fifo_count);
      else passes++;
      reset = 1'b1;
      #1;
      checks++;
      if (txd !== 1'b1) $display("FAIL rst_mid_txd got %b want 1", txd);
      else passes++;
      checks++;
      if (fifo_count !== 3'd0) $display("FAIL rst_mid_count got %0d want 0", fifo_count);
      else passes++;
      checks++;
      if (busy !== 1'b0 || tx_ready !== 1'b1)
         $display("FAIL rst_mid_flags busy %b ready %b want 0 1", busy, tx_ready);
      else passes++;
      step();
      reset = 1'b0;
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (txd !== 1'b1 || busy !== 1'b0) lows++;
      end
      checks++;
      if (lows !== 0) $display("FAIL rst_mid_quiet got %0d active cycles want 0", lows);
      else passes++;
      d = DW'($urandom);
      exp_q = {};
      add_frame(d, 4, 0, 1'b0);
      push_word(d);
      wait_low(4, ok);
      got_q = {};
      got_q.push_back(txd);
      capture_to_end(-10);
      mm = first_mismatch();
      checks++;
      if (!ok || mm !== -1) $display("FAIL rst_mid_resume idx %0d ok %b", mm, ok);
      else passes++;
      step();
   endtask

   task automatic test_ena_stall();
      int mm;
      int pm;
      int j;
      bit ok;
      logic [DW-1:0] d;
      d = DW'($urandom);
      pm = $urandom_range(0, 2);
      j = 8 * 3 + 3;
      ena = 1'b1;
      baud_div = 16'd8;
      parity_mode = 2'(pm);
      two_stop = 1'b0;
      exp_q = {};
      add_frame(d, 8, pm, 1'b0);
      // Data bit 2 stretches from 8 to 11 cycles.
      for (int k = 0; k < 3; k++) exp_q.insert(j + 1, d[2]);
      push_word(d);
      wait_low(4, ok);
      got_q = {};
      got_q.push_back(txd);
      capture_to_end(j);
      mm = first_mismatch();
      checks++;
      if (!ok || mm !== -1)
         $display("FAIL ena_stall d %h pm %0d idx %0d ok %b", d, pm, mm, ok);
      else passes++;
      ena = 1'b1;
      step();
      checks++;
      if (busy !== 1'b0) $display("FAIL ena_stall_end busy %b want 0", busy);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_random();
      test_full();
      test_back_to_back();
      test_reset_mid();
      test_ena_stall();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
